// File: rtl/spi_pkg.sv
// Shared types and SPI mode helpers for the SPI slave.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_state_e;

    function automatic logic lead_is_sample(input int cpha);
        return (cpha == 0);
    endfunction

    function automatic logic idle_level(input int cpol);
        return (cpol != 0);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with one-cycle rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_reg;
    logic [SYNC_STAGES-1:0] chain_next;
    logic                   prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_chain
            if (gi == 0) begin : g_first
                assign chain_next[gi] = d;
            end else begin : g_rest
                assign chain_next[gi] = chain_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= {SYNC_STAGES{RST_VAL}};
            prev_reg  <= RST_VAL;
        end else begin
            chain_reg <= chain_next;
            prev_reg  <= q;
        end
    end

    assign q    = chain_reg[SYNC_STAGES-1];
    assign rise = q & ~prev_reg;
    assign fall = ~q & prev_reg;

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI slave: MSB-first full-duplex frames, one-entry tx holding
// register, rx valid pulse, underrun and partial-frame error pulses.
module spi_slave
    import spi_pkg::*;
#(
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int F_SIZE      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int C_SIZE      = $clog2(F_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [F_SIZE-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [F_SIZE-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              tx_underrun_o,
    output logic              frame_err_o,
    output logic              busy_o,
    input  logic              SCLK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO
);

    localparam logic              IDLE_LVL    = idle_level(CPOL);
    localparam logic              LEAD_SAMPLE = lead_is_sample(CPHA);
    localparam logic [C_SIZE-1:0] CNT_TOP     = C_SIZE'(F_SIZE - 1);

    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_LVL)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .d(CS), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    // MOSI needs no edge detection, only the same latency as SCLK.
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_next;
    logic                   mosi_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_mosi
            if (gi == 0) begin : g_first
                assign mosi_sync_next[gi] = MOSI;
            end else begin : g_rest
                assign mosi_sync_next[gi] = mosi_sync_reg[gi-1];
            end
        end
    endgenerate

    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    // After an edge the synchronized level tells which way it went.
    logic sclk_edge, lead_edge, trail_edge, sample_ok, drive_ok;
    assign sclk_edge  = sclk_rise | sclk_fall;
    assign lead_edge  = sclk_edge & (sclk_q != IDLE_LVL);
    assign trail_edge = sclk_edge & (sclk_q == IDLE_LVL);
    assign sample_ok  = (LEAD_SAMPLE ? lead_edge : trail_edge) & ~cs_rise;
    assign drive_ok   = (LEAD_SAMPLE ? trail_edge : lead_edge) & ~cs_rise;

    spi_state_e        state_reg;
    logic [C_SIZE-1:0] bit_cnt_reg;
    logic [F_SIZE-1:0] tx_shift_reg, rx_shift_reg, rx_shift_next, hold_reg, rx_data_reg;
    logic              tx_ready_reg, rx_valid_reg, underrun_reg, frame_err_reg, busy_reg, miso_reg;

    always_comb begin
        rx_shift_next              = rx_shift_reg;
        rx_shift_next[bit_cnt_reg] = mosi_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync_reg <= '0;
            state_reg     <= IDLE;
            bit_cnt_reg   <= CNT_TOP;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            hold_reg      <= '0;
            rx_data_reg   <= '0;
            tx_ready_reg  <= 1'b1;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
            miso_reg      <= 1'b0;
        end else begin
            mosi_sync_reg <= mosi_sync_next;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            busy_reg      <= ~cs_q;

            // A write is only possible while empty, so it never collides with a LOAD consume.
            if (tx_valid_i && tx_ready_reg) begin
                hold_reg     <= tx_data_i;
                tx_ready_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    miso_reg    <= 1'b0;
                    bit_cnt_reg <= CNT_TOP;
                    if (cs_fall) state_reg <= LOAD;
                end
                LOAD: begin
                    if (!tx_ready_reg) begin
                        tx_shift_reg <= hold_reg;
                        tx_ready_reg <= 1'b1;
                        if (!LEAD_SAMPLE) miso_reg <= miso_reg;
                        else              miso_reg <= hold_reg[F_SIZE-1];
                    end else begin
                        tx_shift_reg <= '0;
                        underrun_reg <= 1'b1;
                        if (LEAD_SAMPLE) miso_reg <= 1'b0;
                    end
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    if (drive_ok) miso_reg <= tx_shift_reg[bit_cnt_reg];
                    if (sample_ok) begin
                        rx_shift_reg <= rx_shift_next;
                        if (bit_cnt_reg == '0) begin
                            rx_data_reg  <= rx_shift_next;
                            rx_valid_reg <= 1'b1;
                            bit_cnt_reg  <= CNT_TOP;
                            state_reg    <= LOAD;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // CS release overrides everything the state logic decided this cycle.
            if (cs_rise) begin
                state_reg    <= IDLE;
                miso_reg     <= 1'b0;
                bit_cnt_reg  <= CNT_TOP;
                rx_shift_reg <= '0;
                if (bit_cnt_reg != CNT_TOP) frame_err_reg <= 1'b1;
            end
        end
    end

    assign tx_ready_o    = tx_ready_reg;
    assign rx_data_o     = rx_data_reg;
    assign rx_valid_o    = rx_valid_reg;
    assign tx_underrun_o = underrun_reg;
    assign frame_err_o   = frame_err_reg;
    assign busy_o        = busy_reg;
    assign MISO          = miso_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 and a mode-3 instance driven by a behavioural SPI master.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sclk, cs_n, mosi, miso;
    logic [1:0] tx_valid, tx_ready, rx_valid, underrun, ferr, busy;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];

    int checks   = 0;
    int failures = 0;
    int rx_cnt   [2];
    int und_cnt  [2];
    int ferr_cnt [2];
    logic [7:0] model_rx [2];

    always #5 clk = ~clk;

    spi_slave #(.CPOL(0), .CPHA(0), .F_SIZE(8), .SYNC_STAGES(2)) u_mode0 (
        .clk(clk), .rst(rst),
        .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]),
        .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]), .tx_underrun_o(underrun[0]),
        .frame_err_o(ferr[0]), .busy_o(busy[0]),
        .SCLK(sclk[0]), .CS(cs_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_slave #(.CPOL(1), .CPHA(1), .F_SIZE(8), .SYNC_STAGES(2)) u_mode3 (
        .clk(clk), .rst(rst),
        .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]),
        .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]), .tx_underrun_o(underrun[1]),
        .frame_err_o(ferr[1]), .busy_o(busy[1]),
        .SCLK(sclk[1]), .CS(cs_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rx_valid[m]) rx_cnt[m]++;
            if (underrun[m]) und_cnt[m]++;
            if (ferr[m])     ferr_cnt[m]++;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_half();
        repeat (8) @(negedge clk);
    endtask

    task automatic write_tx(input int m, input logic [7:0] d);
        int t = 0;
        while (!tx_ready[m] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_before_write", {31'd0, tx_ready[m]}, 32'd1);
        tx_data[m]  = d;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
        check("tx_ready_after_write", {31'd0, tx_ready[m]}, 32'd0);
    endtask

    task automatic cs_assert(input int m, output int und_delta);
        int u0 = und_cnt[m];
        cs_n[m] = 1'b0;
        wait_half();
        und_delta = und_cnt[m] - u0;
    endtask

    task automatic cs_release(input int m);
        cs_n[m] = 1'b1;
        wait_half();
    endtask

    // Mode 0: master shifts on trailing, samples on leading. Mode 3: idle high, drive on fall, sample on rise.
    task automatic xfer(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (m == 0) begin
                mosi[m] = mo[i];
                wait_half();
                sclk[m] = 1'b1;
                got[i]  = miso[m];
                wait_half();
                sclk[m] = 1'b0;
            end else begin
                sclk[m] = 1'b0;
                mosi[m] = mo[i];
                wait_half();
                sclk[m] = 1'b1;
                got[i]  = miso[m];
                wait_half();
            end
        end
        if (m == 0) wait_half();
    endtask

    task automatic exchange(input string name, input int m, input bit pre, input logic [7:0] tx,
                            input logic [7:0] mo, input logic [7:0] exp_got, input int exp_und);
        int r0 = rx_cnt[m];
        int f0 = ferr_cnt[m];
        int und;
        logic [7:0] got;
        if (pre) write_tx(m, tx);
        cs_assert(m, und);
        check({name, "_underrun"}, und, exp_und);
        check({name, "_busy"}, {31'd0, busy[m]}, 32'd1);
        xfer(m, mo, 8, got);
        cs_release(m);
        model_rx[m] = mo;
        check({name, "_miso"}, {24'd0, got}, {24'd0, exp_got});
        check({name, "_rx_data"}, {24'd0, rx_data[m]}, {24'd0, model_rx[m]});
        check({name, "_rx_pulses"}, rx_cnt[m] - r0, 1);
        check({name, "_frame_err"}, ferr_cnt[m] - f0, 0);
        check({name, "_idle"}, {31'd0, busy[m]}, 32'd0);
        $display("xfer %s mode=%0d tx=%02h mosi=%02h miso_got=%02h rx=%02h underrun=%0d",
                 name, m * 3, tx, mo, got, rx_data[m], und);
    endtask

    task automatic check_reset(input int m);
        check("rst_rx_data",  {24'd0, rx_data[m]}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid[m]}, 32'd0);
        check("rst_underrun", {31'd0, underrun[m]}, 32'd0);
        check("rst_ferr",     {31'd0, ferr[m]}, 32'd0);
        check("rst_busy",     {31'd0, busy[m]}, 32'd0);
        check("rst_miso",     {31'd0, miso[m]}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready[m]}, 32'd1);
    endtask

    typedef struct {
        int         mode;
        bit         pre;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_got;
        int         exp_und;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int         und, r0, f0;
        logic [7:0] got1, got2, d, mo;
        bit         wr;
        int         m;

        vecs[0] = '{mode: 0, pre: 1'b1, tx: 8'hA5, mo: 8'h3C, exp_got: 8'hA5, exp_und: 0};
        vecs[1] = '{mode: 1, pre: 1'b1, tx: 8'h81, mo: 8'hF0, exp_got: 8'h81, exp_und: 0};
        vecs[2] = '{mode: 0, pre: 1'b0, tx: 8'h00, mo: 8'h5C, exp_got: 8'h00, exp_und: 1};

        for (int i = 0; i < 2; i++) begin
            rx_cnt[i] = 0; und_cnt[i] = 0; ferr_cnt[i] = 0; model_rx[i] = 8'h00;
            tx_data[i] = 8'h00;
        end
        sclk = 2'b10; cs_n = 2'b11; mosi = 2'b00; tx_valid = 2'b00;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        wait_half();

        for (int i = 0; i < 3; i++)
            exchange($sformatf("vec%0d", i), vecs[i].mode, vecs[i].pre, vecs[i].tx,
                     vecs[i].mo, vecs[i].exp_got, vecs[i].exp_und);

        // Two frames under one CS; second tx word written after frame 1 has loaded.
        r0 = rx_cnt[0];
        write_tx(0, 8'h11);
        cs_assert(0, und);
        write_tx(0, 8'h22);
        xfer(0, 8'h01, 8, got1);
        check("b2b_rx1", {24'd0, rx_data[0]}, 32'h01);
        xfer(0, 8'h02, 8, got2);
        cs_release(0);
        model_rx[0] = 8'h02;
        check("b2b_miso1", {24'd0, got1}, 32'h11);
        check("b2b_miso2", {24'd0, got2}, 32'h22);
        check("b2b_rx_pulses", rx_cnt[0] - r0, 2);
        check("b2b_rx2", {24'd0, rx_data[0]}, {24'd0, model_rx[0]});
        $display("xfer b2b mode=0 miso_got=%02h,%02h rx=%02h", got1, got2, rx_data[0]);

        // CS released after 3 bits.
        r0 = rx_cnt[0];
        f0 = ferr_cnt[0];
        write_tx(0, 8'h77);
        cs_assert(0, und);
        xfer(0, 8'hE7, 3, got1);
        cs_release(0);
        check("abort_frame_err", ferr_cnt[0] - f0, 1);
        check("abort_rx_pulses", rx_cnt[0] - r0, 0);
        check("abort_rx_hold", {24'd0, rx_data[0]}, {24'd0, model_rx[0]});
        $display("xfer abort mode=0 bits=3 frame_err=%0d rx=%02h", ferr_cnt[0] - f0, rx_data[0]);
        exchange("after_abort", 0, 1'b1, 8'h3E, 8'h9D, 8'h3E, 0);

        // Reset mid-frame with a full holding register.
        cs_assert(0, und);
        xfer(0, 8'hFF, 4, got1);
        write_tx(0, 8'hEE);
        rst = 1'b1;
        @(negedge clk);
        check_reset(0);
        cs_n[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_rx[0] = 8'h00;
        model_rx[1] = 8'h00;
        $display("xfer reset mode=0 at bit 4");
        wait_half();
        exchange("after_reset", 0, 1'b1, 8'hC3, 8'h5A, 8'hC3, 0);

        // Random exchanges: the slave returns the written word, or zeros with an underrun.
        for (int i = 0; i < 8; i++) begin
            m  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            mo = 8'($urandom);
            exchange($sformatf("rand%0d", i), m, wr, d, mo, wr ? d : 8'h00, wr ? 0 : 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
